// File: rtl/noc_ctrl_pkg.sv
// Shared types for the NoC layer sequencer: FSM state encoding and error codes.
package noc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_MM,
    S_RQ0,
    S_POST,
    S_RQ1,
    S_WRITE,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LOAD    = 3'd1;
  localparam logic [2:0] ERR_WRITE   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;
  localparam logic [2:0] ERR_CFG     = 3'd5;

  // States that wait on an external completion and are guarded by the watchdog.
  function automatic logic is_wait(state_t s);
    return (s == S_LOAD) || (s == S_MM) || (s == S_RQ0) || (s == S_POST) ||
           (s == S_RQ1) || (s == S_WRITE);
  endfunction

endpackage

// File: rtl/noc_watchdog.sv
// Per-state watchdog: counts while enabled, restarts on clear, flags the last allowed cycle.
module noc_watchdog #(
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TMO_W'(1);
    end
  end

  // A limit of zero disables the watchdog entirely.
  assign expired = (limit != '0) && (count == limit - TMO_W'(1));

endmodule

// File: rtl/noc_tiled_layer_sequencer.sv
// Tile-looping control FSM for one BERT layer stage: loads, MM, requant, optional post-op, write.
module noc_tiled_layer_sequencer
  import noc_ctrl_pkg::*;
#(
  parameter int NUM_LOAD = 2,
  parameter int TILE_W   = 8,
  parameter int TMO_W    = 20
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [TILE_W-1:0]   cfg_num_tiles,
  input  logic                cfg_post_en,
  input  logic [TMO_W-1:0]    cfg_timeout,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          err_code,
  output logic [TILE_W-1:0]   err_tile,
  output logic [TILE_W-1:0]   tile_idx,
  output logic [NUM_LOAD-1:0] start_load,
  input  logic [NUM_LOAD-1:0] load_done,
  input  logic [NUM_LOAD-1:0] load_error,
  output logic                start_wr,
  input  logic                wr_done,
  input  logic                wr_error,
  input  logic                mm_done,
  output logic                start_rq0,
  input  logic                rq0_done,
  output logic                start_post,
  input  logic                post_done,
  output logic                start_rq1,
  input  logic                rq1_done,
  output state_t              dbg_state
);

  localparam int CH_W = (NUM_LOAD > 1) ? $clog2(NUM_LOAD) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_LOAD - 1);

  state_t            state, state_n;
  logic [CH_W-1:0]   ch, ch_n;
  logic [TILE_W-1:0] tile_n, err_tile_n, num_tiles_q;
  logic [2:0]        err_code_n, err_n;
  logic [TMO_W-1:0]  timeout_q;
  logic              post_en_q, start_q, cfg_load, entered, entry, active, wd_expired;

  assign active    = is_wait(state) || (state == S_NEXT);
  assign entered   = (state_n != state) || (ch_n != ch);
  assign dbg_state = state;

  noc_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (entered),
    .en      (is_wait(state)),
    .limit   (timeout_q),
    .expired (wd_expired)
  );

  // Within a cycle: abort beats error inputs, which beat timeout, which beats completion.
  always_comb begin
    state_n    = state;
    ch_n       = ch;
    tile_n     = tile_idx;
    err_n      = ERR_NONE;
    err_code_n = err_code;
    err_tile_n = err_tile;
    cfg_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !start_q) begin
          cfg_load   = 1'b1;
          ch_n       = '0;
          tile_n     = '0;
          err_tile_n = '0;
          if (cfg_num_tiles == '0) begin
            state_n    = S_ERROR;
            err_code_n = ERR_CFG;
          end else begin
            state_n    = S_LOAD;
            err_code_n = ERR_NONE;
          end
        end
      end
      S_LOAD: begin
        if (load_error[ch])     err_n = ERR_LOAD;
        else if (wd_expired)    err_n = ERR_TIMEOUT;
        else if (load_done[ch]) begin
          if (ch == LAST_CH) state_n = S_MM;
          else               ch_n    = ch + CH_W'(1);
        end
      end
      S_MM: begin
        if (wr_error)        err_n   = ERR_WRITE;
        else if (wd_expired) err_n   = ERR_TIMEOUT;
        else if (mm_done)    state_n = S_RQ0;
      end
      S_RQ0: begin
        if (wr_error)        err_n   = ERR_WRITE;
        else if (wd_expired) err_n   = ERR_TIMEOUT;
        else if (rq0_done)   state_n = post_en_q ? S_POST : S_WRITE;
      end
      S_POST: begin
        if (wr_error)        err_n   = ERR_WRITE;
        else if (wd_expired) err_n   = ERR_TIMEOUT;
        else if (post_done)  state_n = S_RQ1;
      end
      S_RQ1: begin
        if (wr_error)        err_n   = ERR_WRITE;
        else if (wd_expired) err_n   = ERR_TIMEOUT;
        else if (rq1_done)   state_n = S_WRITE;
      end
      S_WRITE: begin
        if (wr_error)        err_n   = ERR_WRITE;
        else if (wd_expired) err_n   = ERR_TIMEOUT;
        else if (wr_done)    state_n = S_NEXT;
      end
      S_NEXT: begin
        if (tile_idx == num_tiles_q - TILE_W'(1)) begin
          state_n = S_DONE;
        end else begin
          state_n = S_LOAD;
          ch_n    = '0;
          tile_n  = tile_idx + TILE_W'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (!start) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort && active) err_n = ERR_ABORT;
    if (err_n != ERR_NONE) begin
      state_n    = S_ERROR;
      ch_n       = ch;
      tile_n     = tile_idx;
      err_code_n = err_n;
      err_tile_n = tile_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      ch          <= '0;
      tile_idx    <= '0;
      err_code    <= ERR_NONE;
      err_tile    <= '0;
      start_q     <= 1'b0;
      entry       <= 1'b0;
      num_tiles_q <= '0;
      post_en_q   <= 1'b0;
      timeout_q   <= '0;
    end else begin
      state    <= state_n;
      ch       <= ch_n;
      tile_idx <= tile_n;
      err_code <= err_code_n;
      err_tile <= err_tile_n;
      start_q  <= start;
      entry    <= entered;
      if (cfg_load) begin
        num_tiles_q <= cfg_num_tiles;
        post_en_q   <= cfg_post_en;
        timeout_q   <= cfg_timeout;
      end
    end
  end

  // Start pulses: one cycle, in the cycle after entering the state (or the next load channel).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      start_load <= '0;
      start_wr   <= 1'b0;
      start_rq0  <= 1'b0;
      start_post <= 1'b0;
      start_rq1  <= 1'b0;
    end else begin
      busy       <= active;
      done       <= (state == S_DONE);
      error      <= (state == S_ERROR);
      start_load <= '0;
      if (entry && state == S_LOAD) start_load[ch] <= 1'b1;
      start_wr   <= entry && (state == S_MM);
      start_rq0  <= entry && (state == S_RQ0);
      start_post <= entry && (state == S_POST);
      start_rq1  <= entry && (state == S_RQ1);
    end
  end

endmodule

// File: tb/tb_noc_tiled_layer_sequencer.sv
// Directed bench for the tiled layer sequencer: completion responder, pulse-order scoreboard, error paths.
module tb_noc_tiled_layer_sequencer;
  import noc_ctrl_pkg::*;

  localparam int NUM_LOAD = 2;
  localparam int TILE_W   = 8;
  localparam int TMO_W    = 20;

  logic                clk, rstn, start, abort;
  logic [TILE_W-1:0]   cfg_num_tiles;
  logic                cfg_post_en;
  logic [TMO_W-1:0]    cfg_timeout;
  logic                busy, done, error;
  logic [2:0]          err_code;
  logic [TILE_W-1:0]   err_tile, tile_idx;
  logic [NUM_LOAD-1:0] start_load, load_done, load_error;
  logic                start_wr, wr_done, wr_error, mm_done;
  logic                start_rq0, rq0_done, start_post, post_done, start_rq1, rq1_done;
  state_t              dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  bit post_cfg = 1'b0, hold_mm = 1'b0, hold_rq0 = 1'b0, hold_post = 1'b0, load_both = 1'b0;
  int load_err_tile = -1, load_err_ch = 0;
  int cnt_load[NUM_LOAD];
  bit errp[NUM_LOAD];
  int cnt_mm = 0, cnt_rq0 = 0, cnt_post = 0, cnt_rq1 = 0, cnt_wr = 0;

  noc_tiled_layer_sequencer #(.NUM_LOAD(NUM_LOAD), .TILE_W(TILE_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_num_tiles(cfg_num_tiles), .cfg_post_en(cfg_post_en), .cfg_timeout(cfg_timeout),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .err_tile(err_tile),
    .tile_idx(tile_idx), .start_load(start_load), .load_done(load_done), .load_error(load_error),
    .start_wr(start_wr), .wr_done(wr_done), .wr_error(wr_error), .mm_done(mm_done),
    .start_rq0(start_rq0), .rq0_done(rq0_done), .start_post(start_post), .post_done(post_done),
    .start_rq1(start_rq1), .rq1_done(rq1_done), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Completion responder and pulse monitor: every done follows its start 5 cycles later.
  initial begin
    load_done = '0; load_error = '0; mm_done = 0; rq0_done = 0;
    post_done = 0; rq1_done = 0; wr_done = 0;
    for (int c = 0; c < NUM_LOAD; c++) begin cnt_load[c] = 0; errp[c] = 0; end
    forever begin
      @(negedge clk);
      load_done = '0; load_error = '0; mm_done = 0; rq0_done = 0;
      post_done = 0; rq1_done = 0; wr_done = 0;
      if (!rstn) begin
        for (int c = 0; c < NUM_LOAD; c++) cnt_load[c] = 0;
        cnt_mm = 0; cnt_rq0 = 0; cnt_post = 0; cnt_rq1 = 0; cnt_wr = 0;
      end else begin
        if (cnt_wr > 0) begin cnt_wr--; if (cnt_wr == 0) wr_done = 1; end
        for (int c = 0; c < NUM_LOAD; c++) begin
          if (cnt_load[c] > 0) begin
            cnt_load[c]--;
            if (cnt_load[c] == 0) begin
              if (errp[c]) begin
                load_error[c] = 1'b1;
                if (load_both) load_done[c] = 1'b1;
              end else begin
                load_done[c] = 1'b1;
              end
            end
          end
        end
        if (cnt_mm > 0) begin cnt_mm--; if (cnt_mm == 0) mm_done = 1; end
        if (cnt_rq0 > 0) begin
          cnt_rq0--;
          if (cnt_rq0 == 0) begin rq0_done = 1; if (!post_cfg) cnt_wr = 5; end
        end
        if (cnt_post > 0) begin cnt_post--; if (cnt_post == 0) post_done = 1; end
        if (cnt_rq1 > 0) begin
          cnt_rq1--;
          if (cnt_rq1 == 0) begin rq1_done = 1; cnt_wr = 5; end
        end
        for (int c = 0; c < NUM_LOAD; c++) begin
          if (start_load[c]) begin
            cnt_load[c] = 5;
            errp[c] = (int'(tile_idx) == load_err_tile) && (c == load_err_ch);
            obs_q.push_back({tile_idx[3:0], 4'(c + 1)});
          end
        end
        if (start_wr)   begin if (!hold_mm) cnt_mm = 5;     obs_q.push_back({tile_idx[3:0], 4'd3}); end
        if (start_rq0)  begin if (!hold_rq0) cnt_rq0 = 5;   obs_q.push_back({tile_idx[3:0], 4'd4}); end
        if (start_post) begin if (!hold_post) cnt_post = 5; obs_q.push_back({tile_idx[3:0], 4'd5}); end
        if (start_rq1)  begin cnt_rq1 = 5;                  obs_q.push_back({tile_idx[3:0], 4'd6}); end
      end
    end
  end

  // Scoreboard helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tile(input int t, input bit post);
    exp_q.push_back({4'(t), 4'd1});
    exp_q.push_back({4'(t), 4'd2});
    exp_q.push_back({4'(t), 4'd3});
    exp_q.push_back({4'(t), 4'd4});
    if (post) begin
      exp_q.push_back({4'(t), 4'd5});
      exp_q.push_back({4'(t), 4'd6});
    end
  endtask

  task automatic ev_check(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic launch(input logic [TILE_W-1:0] tiles, input bit post, input logic [TMO_W-1:0] tmo);
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    cfg_num_tiles = tiles;
    cfg_post_en   = post;
    cfg_timeout   = tmo;
    post_cfg      = post;
    start         = 1'b1;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // which: 0 start_wr, 1 start_post, 2 start_rq0, 3 in WRITE, 4 done or error
  task automatic wait_cond(input int which, input int max, input string tag);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < max) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = start_wr;
        1: hit = start_post;
        2: hit = start_rq0;
        3: hit = (dbg_state == S_WRITE);
        default: hit = done || error;
      endcase
    end
    chk({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    rstn = 0; start = 0; abort = 0; wr_error = 0;
    cfg_num_tiles = '0; cfg_post_en = 0; cfg_timeout = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_tile_idx", 32'(tile_idx), 0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rstn = 1;

    // 1: three tiles with post-op
    launch(8'd3, 1'b1, '0);
    push_tile(0, 1); push_tile(1, 1); push_tile(2, 1);
    wait_cond(4, 1000, "t1_end");
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_tile_idx", 32'(tile_idx), 2);
    chk("t1_err_code", 32'(err_code), 0);
    ev_check("t1");
    release_start();
    chk("t1_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("t1_done_low", 32'(done), 0);

    // 2: post-op bypass
    launch(8'd1, 1'b0, '0);
    push_tile(0, 0);
    wait_cond(4, 500, "t2_end");
    chk("t2_done", 32'(done), 1);
    ev_check("t2");
    release_start();

    // 3: load error on channel 1 of tile 1
    load_err_tile = 1; load_err_ch = 1;
    launch(8'd2, 1'b1, '0);
    push_tile(0, 1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    wait_cond(4, 1000, "t3_end");
    chk("t3_error", 32'(error), 1);
    chk("t3_err_code", 32'(err_code), 32'(ERR_LOAD));
    chk("t3_err_tile", 32'(err_tile), 1);
    chk("t3_busy", 32'(busy), 0);
    ev_check("t3");
    release_start();
    chk("t3_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("t3_err_hold", 32'(err_code), 32'(ERR_LOAD));
    load_err_tile = -1;

    // 4: watchdog fires 16 cycles after MM entry
    hold_mm = 1;
    launch(8'd1, 1'b0, 20'd16);
    wait_cond(0, 200, "t4_mm");
    repeat (14) @(negedge clk);
    chk("t4_pre_code", 32'(err_code), 0);
    chk("t4_pre_state", 32'(dbg_state), 32'(S_MM));
    @(negedge clk);
    chk("t4_code", 32'(err_code), 32'(ERR_TIMEOUT));
    @(negedge clk);
    chk("t4_error", 32'(error), 1);
    release_start();

    // 4b: timeout disabled, MM withheld for 10000 cycles, then abort
    launch(8'd1, 1'b0, '0);
    wait_cond(0, 200, "t4b_mm");
    repeat (10000) @(negedge clk);
    chk("t4b_no_error", 32'(error), 0);
    chk("t4b_busy", 32'(busy), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    @(negedge clk);
    chk("t4b_abort_code", 32'(err_code), 32'(ERR_ABORT));
    release_start();
    hold_mm = 0;

    // 5: abort during POST
    hold_post = 1;
    launch(8'd1, 1'b1, '0);
    wait_cond(1, 300, "t5_post");
    abort = 1;
    @(negedge clk);
    abort = 0;
    @(negedge clk);
    chk("t5_abort_error", 32'(error), 1);
    chk("t5_abort_code", 32'(err_code), 32'(ERR_ABORT));
    release_start();
    hold_post = 0;

    // 5b: write error during RQ0
    hold_rq0 = 1;
    launch(8'd1, 1'b1, '0);
    wait_cond(2, 300, "t5b_rq0");
    wr_error = 1;
    @(negedge clk);
    wr_error = 0;
    @(negedge clk);
    chk("t5b_error", 32'(error), 1);
    chk("t5b_code", 32'(err_code), 32'(ERR_WRITE));
    release_start();
    hold_rq0 = 0;

    // 5c: load_done and load_error together
    load_err_tile = 0; load_err_ch = 0; load_both = 1;
    launch(8'd1, 1'b0, '0);
    exp_q.push_back(8'h01);
    wait_cond(4, 300, "t5c_end");
    chk("t5c_error", 32'(error), 1);
    chk("t5c_code", 32'(err_code), 32'(ERR_LOAD));
    chk("t5c_tile", 32'(err_tile), 0);
    ev_check("t5c");
    release_start();
    load_err_tile = -1; load_both = 0;

    // 6: zero tiles
    launch(8'd0, 1'b1, '0);
    wait_cond(4, 50, "t6_end");
    chk("t6_error", 32'(error), 1);
    chk("t6_code", 32'(err_code), 32'(ERR_CFG));
    chk("t6_busy", 32'(busy), 0);
    ev_check("t6");
    release_start();

    // 6b: reset in WRITE, then a clean two-tile run
    launch(8'd1, 1'b0, '0);
    wait_cond(3, 300, "t6b_write");
    rstn = 0;
    @(negedge clk);
    chk("t6b_state", 32'(dbg_state), 32'(S_IDLE));
    chk("t6b_busy", 32'(busy), 0);
    chk("t6b_tile", 32'(tile_idx), 0);
    chk("t6b_code", 32'(err_code), 0);
    chk("t6b_pulses", 32'({start_load, start_wr, start_rq0, start_post, start_rq1}), 0);
    rstn = 1;
    start = 0;
    @(negedge clk);
    launch(8'd2, 1'b1, '0);
    push_tile(0, 1); push_tile(1, 1);
    wait_cond(4, 1000, "t6c_end");
    chk("t6c_done", 32'(done), 1);
    chk("t6c_tile", 32'(tile_idx), 1);
    chk("t6c_code", 32'(err_code), 0);
    ev_check("t6c");
    release_start();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
